// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter in front of a single-port synchronous RAM.
// One request is in flight at a time: IDLE -> ACCESS -> (WAIT) -> RESP.
module mem_arbiter_ctrl #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 8,
    parameter int NPORTS     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_valid,
    input  logic [NPORTS-1:0]        req_rw,
    input  logic [NPORTS*AWIDTH-1:0] req_addr,
    input  logic [NPORTS*DWIDTH-1:0] req_wdata,
    output logic [NPORTS-1:0]        req_ready,
    output logic [NPORTS-1:0]        rsp_valid,
    output logic [DWIDTH-1:0]        rsp_data,
    output logic                     rdEn,
    output logic                     wrEn,
    output logic [AWIDTH-1:0]        Addr,
    output logic [DWIDTH-1:0]        WrData,
    input  logic [DWIDTH-1:0]        RdData
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   port_q;
    logic [PW:0]     idx;
    logic            found;
    logic            accept;
    logic            rw_q;
    logic [CW-1:0]   cnt;

    // Search from ptr upward, wrapping at NPORTS; first requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NPORTS)) begin
                idx = idx - (PW+1)'(NPORTS);
            end
            if (!found && req_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                grant = idx[PW-1:0];
            end
        end
    end

    assign accept = (state == IDLE) && !reset && found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rdEn      = 1'b0;
        wrEn      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACCESS;
                    req_ready = NPORTS'(1) << grant;
                end
            end
            ACCESS: begin
                state_nxt = rw_q ? WAIT : RESP;
                rdEn      = !reset && rw_q;
                wrEn      = !reset && !rw_q;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (!reset) begin
                    rsp_valid = NPORTS'(1) << port_q;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, pointer advance, read-latency countdown and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            port_q   <= '0;
            rw_q     <= 1'b0;
            cnt      <= '0;
            Addr     <= '0;
            WrData   <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                port_q <= grant;
                rw_q   <= req_rw[grant];
                Addr   <= req_addr[grant*AWIDTH +: AWIDTH];
                WrData <= req_wdata[grant*DWIDTH +: DWIDTH];
                ptr    <= (grant == PW'(NPORTS-1)) ? '0 : grant + PW'(1);
            end
            if (state == ACCESS && rw_q) begin
                cnt <= CW'(RD_LATENCY-1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state == WAIT && cnt == '0) begin
                rsp_data <= RdData;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl (3 ports, read latency 2) with a RAM model
// and a scoreboard of expected responses popped by an independent monitor.
module tb_mem_arbiter_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NP = 3;
    localparam int RL = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_rw;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rdEn;
    logic             wrEn;
    logic [AW-1:0]    Addr;
    logic [DW-1:0]    WrData;
    logic [DW-1:0]    RdData;

    mem_arbiter_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .NPORTS(NP), .RD_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rdEn(rdEn), .wrEn(wrEn),
        .Addr(Addr), .WrData(WrData), .RdData(RdData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: two-stage read pipeline gives RD_LATENCY = 2
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_s1;
    always @(posedge clk) begin
        if (wrEn) mem[Addr] <= WrData;
        if (rdEn) rd_s1 <= mem[Addr];
        RdData <= rd_s1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] data;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [31:0] exp_last_rd = 32'h0;

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < NP; i++) begin
            if (req_ready[i] === 1'b1) grant_log.push_back(i);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", 64'(rsp_valid), 64'(1) << e.port);
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    // Present a request on port p and hold it until accepted; called at a negedge.
    task automatic issue(input int p, input bit rd, input logic [7:0] a, input logic [31:0] d,
                         input logic [31:0] rexp, input bit keep, input bit track, output int t);
        int n;
        n = 0;
        req_rw[p] = rd;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
        req_valid[p] = 1'b1;
        #1;
        while (req_ready[p] !== 1'b1 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_ready[p] !== 1'b1) begin
            chk("accept_timeout", 64'(req_ready[p]), 64'h1);
            req_valid[p] = 1'b0;
            t = -1;
        end else begin
            t = cyc;
            if (track) begin
                if (rd) exp_last_rd = rexp;
                sb.push_back('{p, rd ? rexp : exp_last_rd, cyc + (rd ? 2 + RL : 2)});
            end
            @(posedge clk);
            #1;
            if (!keep) req_valid[p] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, ta, tb, tc, base, n;
        req_valid = '1;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;

        #1;
        chk("rst_ready_t0", 64'(req_ready), 64'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'h0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
            chk("rst_rdEn", 64'(rdEn), 64'h0);
            chk("rst_wrEn", 64'(wrEn), 64'h0);
        end
        reset = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'h0);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("post_rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("post_rst_rdEn", 64'(rdEn), 64'h0);
        chk("post_rst_wrEn", 64'(wrEn), 64'h0);
        chk("post_rst_Addr", 64'(Addr), 64'h0);
        chk("post_rst_WrData", 64'(WrData), 64'h0);

        // Single write, then read-back on another port
        issue(0, 1'b0, 8'h00, 32'h12345678, 32'h0, 1'b0, 1'b1, t0);
        chk("wr_wrEn", 64'(wrEn), 64'h1);
        chk("wr_rdEn", 64'(rdEn), 64'h0);
        chk("wr_Addr", 64'(Addr), 64'h00);
        chk("wr_WrData", 64'(WrData), 64'h12345678);
        chk("wr_ready_t1", 64'(req_ready), 64'h0);
        @(negedge clk);
        chk("wr_ready_t2", 64'(req_ready), 64'h0);

        issue(1, 1'b1, 8'h00, 32'h0, 32'h12345678, 1'b0, 1'b1, t1);
        chk("rd_rdEn", 64'(rdEn), 64'h1);
        chk("rd_wrEn", 64'(wrEn), 64'h0);
        chk("rd_Addr", 64'(Addr), 64'h00);
        chk("wr_to_rd_accept_gap", 64'(t1 - t0), 64'd3);
        issue(2, 1'b0, 8'h01, 32'h00000077, 32'h0, 1'b0, 1'b1, t2);
        chk("rd_next_accept_gap", 64'(t2 - t1), 64'd5);

        // Three simultaneous writes, then three simultaneous reads
        base = grant_log.size();
        fork
            issue(0, 1'b0, 8'h10, 32'h000000A0, 32'h0, 1'b0, 1'b1, ta);
            issue(1, 1'b0, 8'h11, 32'h000000B1, 32'h0, 1'b0, 1'b1, tb);
            issue(2, 1'b0, 8'h12, 32'h000000C2, 32'h0, 1'b0, 1'b1, tc);
        join
        chk("wr3_grant0", 64'(grant_log[base]), 64'd0);
        chk("wr3_grant1", 64'(grant_log[base+1]), 64'd1);
        chk("wr3_grant2", 64'(grant_log[base+2]), 64'd2);
        chk("wr3_gap", 64'(tc - ta), 64'd6);

        base = grant_log.size();
        fork
            issue(0, 1'b1, 8'h10, 32'h0, 32'h000000A0, 1'b0, 1'b1, ta);
            issue(1, 1'b1, 8'h11, 32'h0, 32'h000000B1, 1'b0, 1'b1, tb);
            issue(2, 1'b1, 8'h12, 32'h0, 32'h000000C2, 1'b0, 1'b1, tc);
        join
        chk("rd3_grant0", 64'(grant_log[base]), 64'd0);
        chk("rd3_grant1", 64'(grant_log[base+1]), 64'd1);
        chk("rd3_grant2", 64'(grant_log[base+2]), 64'd2);
        chk("rd3_gap", 64'(tc - ta), 64'd10);

        // Ports 0 and 2 hold valid; port 1 joins once three grants have gone out
        base = grant_log.size();
        fork
            begin
                int x0;
                issue(0, 1'b0, 8'h20, 32'h00000200, 32'h0, 1'b1, 1'b1, x0);
                issue(0, 1'b0, 8'h21, 32'h00000201, 32'h0, 1'b0, 1'b1, x0);
            end
            begin
                int x2;
                issue(2, 1'b0, 8'h30, 32'h00000300, 32'h0, 1'b1, 1'b1, x2);
                issue(2, 1'b0, 8'h31, 32'h00000301, 32'h0, 1'b0, 1'b1, x2);
            end
            begin
                int x1, w;
                w = 0;
                while (grant_log.size() < base + 3 && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                issue(1, 1'b0, 8'h40, 32'h00000400, 32'h0, 1'b0, 1'b1, x1);
            end
        join
        chk("rr_grant_a", 64'(grant_log[base]), 64'd0);
        chk("rr_grant_b", 64'(grant_log[base+1]), 64'd2);
        chk("rr_grant_c", 64'(grant_log[base+2]), 64'd0);
        chk("rr_grant_d", 64'(grant_log[base+3]), 64'd1);
        chk("rr_grant_e", 64'(grant_log[base+4]), 64'd2);

        // Read abandoned by reset in its first WAIT cycle
        issue(2, 1'b1, 8'hFF, 32'h0, 32'h0, 1'b0, 1'b0, t0);
        chk("abort_rdEn", 64'(rdEn), 64'h1);
        chk("abort_Addr", 64'(Addr), 64'hFF);
        @(negedge clk);
        reset = 1'b1;
        req_valid[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_hold_ready", 64'(req_ready), 64'h0);
        chk("rst_mid_rsp_data", 64'(rsp_data), 64'h0);
        chk("rst_mid_Addr", 64'(Addr), 64'h0);
        chk("rst_mid_WrData", 64'(WrData), 64'h0);
        reset = 1'b0;
        req_valid = '0;
        exp_last_rd = 32'h0;
        repeat (5) @(negedge clk);

        base = grant_log.size();
        fork
            issue(1, 1'b0, 8'h50, 32'h00000055, 32'h0, 1'b0, 1'b1, ta);
            issue(2, 1'b0, 8'hFF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, tb);
        join
        chk("post_abort_grant0", 64'(grant_log[base]), 64'd1);
        chk("post_abort_grant1", 64'(grant_log[base+1]), 64'd2);
        issue(2, 1'b1, 8'hFF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, t0);
        chk("top_addr_rdEn", 64'(rdEn), 64'h1);
        chk("top_addr_Addr", 64'(Addr), 64'hFF);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
